// File: rtl/pll_lock_monitor_if.sv
// Bundles the monitor's control inputs and measurement outputs into one port.
// Latency: none, wires only.
// Backpressure: none; the outputs are status signals the reader samples when it likes.
interface pll_lock_monitor_if #(
    parameter int CNT_W = 8
);
    // Controls and the reference, driven by housekeeping logic
    logic             enable;
    logic             osc;
    logic [4:0]       div;
    logic [2:0]       tol;

    // Measurement results, driven by the monitor
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             locked;
    logic             timeout;

    // Housekeeping side: drives the controls and reads the results
    modport master (
        output enable,
        output osc,
        output div,
        output tol,
        input  count,
        input  count_valid,
        input  locked,
        input  timeout
    );

    // Monitor side
    modport slave (
        input  enable,
        input  osc,
        input  div,
        input  tol,
        output count,
        output count_valid,
        output locked,
        output timeout
    );
endinterface

// File: rtl/pll_lock_monitor.sv
// Measures the osc period in PLL clock cycles and tracks lock against div +/- tol.
// Latency: osc high at sampling edge k gives count_valid in the cycle after edge k+2.
// Backpressure: none; count_valid is a single-cycle pulse and is not held for the reader.
module pll_lock_monitor #(
    parameter int CNT_W      = 8,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic              clock,
    input  logic              resetb,
    pll_lock_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // A period counter stuck at this value means the reference edge never arrived
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_TH   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_TH = 4'(UNLOCK_CNT);
    localparam logic [3:0]       RUN_MAX   = 4'hF;

    // Reference synchroniser and edge history
    logic s1;
    logic s2;
    logic s3;
    logic osc_rise;

    // Control state
    state_t state;
    state_t state_nxt;

    // Datapath registers and their next values
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] period_cnt_nxt;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             count_valid_q;
    logic             count_valid_nxt;
    logic             locked_q;
    logic             locked_nxt;
    logic             timeout_q;
    logic             timeout_nxt;
    logic [3:0]       good_run;
    logic [3:0]       good_run_nxt;
    logic [3:0]       bad_run;
    logic [3:0]       bad_run_nxt;

    // Tolerance test of the period that is about to be reported
    logic [CNT_W:0]   meas_ext;
    logic [CNT_W:0]   div_ext;
    logic [CNT_W:0]   tol_ext;
    logic [CNT_W:0]   abs_diff;
    logic             meas_good;
    logic [3:0]       good_inc;
    logic [3:0]       bad_inc;

    // Two-flop synchroniser on the asynchronous reference plus a history flop
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.osc;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // A rising reference edge is one cycle of synchronised high after low
    assign osc_rise = s2 & ~s3;

    // Error magnitude is taken one bit wider so the subtraction never wraps
    assign meas_ext  = {1'b0, period_cnt};
    assign div_ext   = (CNT_W + 1)'(bus.div);
    assign tol_ext   = (CNT_W + 1)'(bus.tol);
    assign abs_diff  = (meas_ext >= div_ext) ? (meas_ext - div_ext)
                                             : (div_ext - meas_ext);
    // A zero ratio is never a valid target, so it can never produce lock
    assign meas_good = (bus.div != 5'd0) && (abs_diff <= tol_ext);

    // Run counters saturate instead of wrapping back below the thresholds
    assign good_inc  = (good_run == RUN_MAX) ? RUN_MAX : good_run + 4'd1;
    assign bad_inc   = (bad_run  == RUN_MAX) ? RUN_MAX : bad_run  + 4'd1;

    // State register
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and next datapath values
    always_comb begin
        state_nxt       = state;
        period_cnt_nxt  = period_cnt;
        count_nxt       = count_q;
        count_valid_nxt = 1'b0;
        locked_nxt      = locked_q;
        timeout_nxt     = timeout_q;
        good_run_nxt    = good_run;
        bad_run_nxt     = bad_run;

        if (!bus.enable) begin
            // Disable wipes everything, including a pending timeout
            state_nxt      = IDLE;
            period_cnt_nxt = '0;
            count_nxt      = '0;
            locked_nxt     = 1'b0;
            timeout_nxt    = 1'b0;
            good_run_nxt   = '0;
            bad_run_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARM;
                end

                ARM: begin
                    // The first edge only opens a window; nothing to report yet
                    if (osc_rise) begin
                        period_cnt_nxt = CNT_ONE;
                        state_nxt      = MEASURE;
                    end
                end

                MEASURE: begin
                    if (osc_rise) begin
                        // An edge wins even in the saturation cycle
                        count_nxt       = period_cnt;
                        count_valid_nxt = 1'b1;
                        period_cnt_nxt  = CNT_ONE;
                        timeout_nxt     = 1'b0;
                        if (meas_good) begin
                            good_run_nxt = good_inc;
                            bad_run_nxt  = '0;
                            if (good_inc == LOCK_TH) begin
                                locked_nxt = 1'b1;
                            end
                        end else begin
                            bad_run_nxt  = bad_inc;
                            good_run_nxt = '0;
                            if (bad_inc == UNLOCK_TH) begin
                                locked_nxt = 1'b0;
                            end
                        end
                    end else if (period_cnt == CNT_MAX) begin
                        // Reference lost: drop lock and wait for a fresh window
                        timeout_nxt    = 1'b1;
                        locked_nxt     = 1'b0;
                        good_run_nxt   = '0;
                        bad_run_nxt    = '0;
                        period_cnt_nxt = '0;
                        state_nxt      = ARM;
                    end else begin
                        period_cnt_nxt = period_cnt + CNT_ONE;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            period_cnt    <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
            good_run      <= '0;
            bad_run       <= '0;
        end else begin
            period_cnt    <= period_cnt_nxt;
            count_q       <= count_nxt;
            count_valid_q <= count_valid_nxt;
            locked_q      <= locked_nxt;
            timeout_q     <= timeout_nxt;
            good_run      <= good_run_nxt;
            bad_run       <= bad_run_nxt;
        end
    end

    assign bus.count       = count_q;
    assign bus.count_valid = count_valid_q;
    assign bus.locked      = locked_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: osc pulses at hand-chosen spacings.
// Latency: pulses are logged on the falling clock edge and compared in groups.
// Backpressure: not applicable; the monitor has no ready input.
module tb_pll_lock_monitor;

    logic clock = 1'b0;
    logic resetb;

    always #5 clock = ~clock;

    pll_lock_monitor_if #(.CNT_W(8)) bus ();

    pll_lock_monitor #(
        .CNT_W      (8),
        .LOCK_CNT   (4),
        .UNLOCK_CNT (2)
    ) dut (
        .clock  (clock),
        .resetb (resetb),
        .bus    (bus)
    );

    typedef struct {
        int cnt;
        int lck;
        int tmo;
    } pulse_t;

    pulse_t pulses[$];
    int     nz_cycles = 0;
    int     n_checks  = 0;
    int     n_pass    = 0;
    int     since_rise = 0;
    int     exp_c[16];
    int     exp_l[16];
    int     per3[10];
    int     base;
    int     nz_base;

    // Log every count_valid pulse and any cycle with a nonzero output
    always @(negedge clock) begin
        if (bus.count_valid) begin
            pulses.push_back('{int'(bus.count), int'(bus.locked), int'(bus.timeout)});
        end
        if ((bus.count != 8'd0) || bus.count_valid || bus.locked || bus.timeout) begin
            nz_cycles = nz_cycles + 1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got == exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        since_rise = since_rise + 1;
    endtask

    // Raise osc for one cycle, p falling edges after the previous rise
    task automatic period(input int p);
        bus.osc = 1'b0;
        while (since_rise < p) tick();
        bus.osc = 1'b1;
        since_rise = 0;
        tick();
        bus.osc = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.osc = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_count"}, int'(bus.count), 0);
        check({tag, "_valid"}, int'(bus.count_valid), 0);
        check({tag, "_locked"}, int'(bus.locked), 0);
        check({tag, "_timeout"}, int'(bus.timeout), 0);
    endtask

    // Compare the pulses logged since index b against exp_c / exp_l
    task automatic check_group(input string tag, input int b, input int n);
        check({tag, "_npulse"}, pulses.size() - b, n);
        for (int i = 0; i < n; i++) begin
            if (b + i < pulses.size()) begin
                check($sformatf("%s_cnt%0d", tag, i), pulses[b + i].cnt, exp_c[i]);
                check($sformatf("%s_lck%0d", tag, i), pulses[b + i].lck, exp_l[i]);
                check($sformatf("%s_tmo%0d", tag, i), pulses[b + i].tmo, 0);
            end
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetb     = 1'b0;
        bus.enable = 1'b0;
        bus.osc    = 1'b0;
        bus.div    = 5'd0;
        bus.tol    = 3'd0;
        repeat (3) tick();
        check_outputs_zero("reset");
        resetb = 1'b1;

        // Disabled: osc toggles, nothing may ever come out
        base    = pulses.size();
        nz_base = nz_cycles;
        repeat (6) period(4);
        drain(4);
        check("dis_pulses", pulses.size() - base, 0);
        check("dis_nz_cycles", nz_cycles - nz_base, 0);

        // Period 8 against div 8 tol 1: ARM edge, then four good pulses, lock on the 4th
        bus.div    = 5'd8;
        bus.tol    = 3'd1;
        bus.enable = 1'b1;
        base = pulses.size();
        repeat (5) period(8);
        drain(4);
        exp_c = '{8, 8, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_l = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_group("lock", base, 4);

        // Within tolerance keeps lock, two bad in a row drop it, four good relock
        per3  = '{9, 7, 11, 8, 11, 11, 8, 8, 8, 8};
        base = pulses.size();
        foreach (per3[i]) period(per3[i]);
        drain(4);
        exp_c = '{9, 7, 11, 8, 11, 11, 8, 8, 8, 8, 0, 0, 0, 0, 0, 0};
        exp_l = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        check_group("track", base, 10);

        // osc held low: the timeout lands exactly 258 falling edges after the last rise
        while (since_rise < 257) tick();
        check("pre_tmo_timeout", int'(bus.timeout), 0);
        check("pre_tmo_locked", int'(bus.locked), 1);
        tick();
        check("tmo_timeout", int'(bus.timeout), 1);
        check("tmo_locked", int'(bus.locked), 0);

        // Resume: first edge only re-arms, timeout holds until the next pulse
        base = pulses.size();
        period(8);
        drain(5);
        check("rearm_npulse", pulses.size() - base, 0);
        check("rearm_timeout_held", int'(bus.timeout), 1);
        period(8);
        drain(4);
        exp_c = '{8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_group("resume", base, 1);
        check("resume_timeout", int'(bus.timeout), 0);

        // Edge in the saturation cycle is a normal 255 measurement
        base = pulses.size();
        period(255);
        drain(4);
        exp_c = '{255, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_group("sat", base, 1);
        check("sat_timeout", int'(bus.timeout), 0);

        // Reset mid-period clears outputs without waiting for a clock
        drain(10);
        check("pre_rst_count", int'(bus.count), 255);
        resetb = 1'b0;
        #1;
        check_outputs_zero("midrst");
        tick();
        resetb = 1'b1;

        // div 0 never counts as good, so period 3 never locks
        bus.div = 5'd0;
        bus.tol = 3'd7;
        base = pulses.size();
        repeat (5) period(3);
        drain(4);
        exp_c = '{3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_l = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_group("div0", base, 4);
        check("div0_locked", int'(bus.locked), 0);

        // Disable mid-period clears outputs on the next clock
        check("pre_dis_count", int'(bus.count), 3);
        bus.enable = 1'b0;
        tick();
        check_outputs_zero("dis");

        // Re-enable: one ARM edge first, then a 3-clock latency pulse with count 3
        tick();
        bus.enable = 1'b1;
        base = pulses.size();
        period(6);
        period(3);
        tick();
        check("lat_before", int'(bus.count_valid), 0);
        tick();
        check("lat_valid", int'(bus.count_valid), 1);
        check("lat_count", int'(bus.count), 3);
        drain(3);
        check("reen_npulse", pulses.size() - base, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
